// File: rtl/arbitro_1.sv
// Four-to-one fan-in arbiter: drains per-class FIFOs into one output FIFO
// in round-robin order, with at most BURST pops per grant.
module arbitro_1 #(
   parameter int BURST = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] FIFO_empty,
   input  logic       Almost_full,
   output logic [3:0] Pop,
   output logic       Push,
   output logic [1:0] class_o,
   output logic       Idle
);

   typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

   localparam logic [3:0] BURST_W = 4'(BURST);

   state_t     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic [1:0] last_grant_q, last_grant_d;
   logic [2:0] count_q, count_d;
   logic [1:0] class_q, class_d;

   logic [1:0] winner;
   logic [1:0] idx;
   logic       any_req;
   logic       fire;
   logic [3:0] count_inc;

   // Scanning from the farthest candidate back lets the nearest one overwrite it.
   always_comb begin
      winner = last_grant_q + 2'd1;
      idx    = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         idx = last_grant_q + 2'(k);
         if (!FIFO_empty[idx]) winner = idx;
      end
   end

   assign any_req   = ~&FIFO_empty;
   assign count_inc = {1'b0, count_q} + 4'd1;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      count_d      = count_q;
      class_d      = class_q;
      fire         = 1'b0;
      Pop          = 4'b0000;
      Push         = 1'b0;
      Idle         = 1'b0;
      case (state_q)
         IDLE: begin
            Idle = 1'b1;
            if (any_req) begin
               state_d = SERVE;
               grant_d = winner;
               class_d = winner;
               count_d = 3'd0;
            end
         end
         SERVE: begin
            fire = !FIFO_empty[grant_q] && !Almost_full;
            Pop  = fire ? (4'b0001 << grant_q) : 4'b0000;
            Push = fire;
            // An empty granted FIFO releases even under backpressure.
            if (FIFO_empty[grant_q] || (fire && (count_inc >= BURST_W))) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
               count_d      = 3'd0;
            end else if (fire) begin
               count_d = count_inc[2:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= 2'd0;
         last_grant_q <= 2'd3;
         count_q      <= 3'd0;
         class_q      <= 2'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         count_q      <= count_d;
         class_q      <= class_d;
      end
   end

   assign class_o = class_q;

endmodule

// File: tb/tb_arbitro_1.sv
// Directed bench for arbitro_1: one table row per clock cycle with
// hand-computed outputs, plus a hand-written reset-inside-a-burst sequence.
module tb_arbitro_1;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] FIFO_empty;
   logic       Almost_full;
   logic [3:0] Pop;
   logic       Push;
   logic [1:0] class_o;
   logic       Idle;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       rst;
      logic [3:0] emp;
      logic       af;
      logic [3:0] pop;
      logic       push;
      logic [1:0] cls;
      logic       idle;
      int         test;
   } vec_t;

   vec_t tbl[$];

   arbitro_1 #(.BURST(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .FIFO_empty  (FIFO_empty),
      .Almost_full (Almost_full),
      .Pop         (Pop),
      .Push        (Push),
      .class_o     (class_o),
      .Idle        (Idle)
   );

   always #5 clk = ~clk;

   task automatic add(input logic rst, input logic [3:0] emp, input logic af,
                      input logic [3:0] pop, input logic push, input logic [1:0] cls,
                      input logic idle, input int test);
      vec_t v;
      v.rst = rst; v.emp = emp; v.af = af; v.pop = pop;
      v.push = push; v.cls = cls; v.idle = idle; v.test = test;
      tbl.push_back(v);
   endtask

   task automatic check(input int test, input int row, input logic [3:0] pop,
                        input logic push, input logic [1:0] cls, input logic idle);
      n_vec++;
      if (Pop !== pop || Push !== push || class_o !== cls || Idle !== idle) begin
         n_err++;
         $display("FAIL t%0d row%0d: got Pop=%b Push=%b class=%0d Idle=%b, want Pop=%b Push=%b class=%0d Idle=%b",
                  test, row, Pop, Push, class_o, Idle, pop, push, cls, idle);
      end
   endtask

   initial begin
      logic [3:0] onehot;
      int g;
      reset       = 1'b1;
      FIFO_empty  = 4'hF;
      Almost_full = 1'b0;

      // reset, all empty
      add(1, 4'hF, 0, 4'h0, 0, 2'd0, 1, 1);
      for (int i = 0; i < 20; i++) add(0, 4'hF, 0, 4'h0, 0, 2'd0, 1, 1);

      // single class, six entries in FIFO 0
      add(0, 4'hE, 0, 4'h0, 0, 2'd0, 1, 2);
      for (int i = 0; i < 4; i++) add(0, 4'hE, 0, 4'h1, 1, 2'd0, 0, 2);
      add(0, 4'hE, 0, 4'h0, 0, 2'd0, 1, 2);
      for (int i = 0; i < 2; i++) add(0, 4'hE, 0, 4'h1, 1, 2'd0, 0, 2);
      add(0, 4'hF, 0, 4'h0, 0, 2'd0, 0, 2);
      add(0, 4'hF, 0, 4'h0, 0, 2'd0, 1, 2);

      // all four busy after a fresh reset: order 0,1,2,3,0
      add(1, 4'h0, 0, 4'h0, 0, 2'd0, 1, 3);
      add(0, 4'h0, 0, 4'h0, 0, 2'd0, 1, 3);
      for (int gi = 0; gi < 5; gi++) begin
         g      = gi % 4;
         onehot = 4'b0001 << g;
         for (int i = 0; i < 4; i++) add(0, 4'h0, 0, onehot, 1, 2'(g), 0, 3);
         add(0, (gi == 4) ? 4'hF : 4'h0, 0, 4'h0, 0, 2'(g), 1, 3);
      end

      // backpressure on FIFO 2 after two pops
      add(0, 4'hB, 0, 4'h0, 0, 2'd0, 1, 4);
      for (int i = 0; i < 2; i++) add(0, 4'hB, 0, 4'h4, 1, 2'd2, 0, 4);
      for (int i = 0; i < 3; i++) add(0, 4'hB, 1, 4'h0, 0, 2'd2, 0, 4);
      for (int i = 0; i < 2; i++) add(0, 4'hB, 0, 4'h4, 1, 2'd2, 0, 4);
      add(0, 4'hF, 0, 4'h0, 0, 2'd2, 1, 4);
      add(0, 4'hF, 0, 4'h0, 0, 2'd2, 1, 4);

      // early empty: FIFO 1 one entry (empties under Almost_full), FIFO 2 five
      add(0, 4'h9, 0, 4'h0, 0, 2'd2, 1, 5);
      add(0, 4'h9, 0, 4'h2, 1, 2'd1, 0, 5);
      add(0, 4'hB, 1, 4'h0, 0, 2'd1, 0, 5);
      add(0, 4'hB, 0, 4'h0, 0, 2'd1, 1, 5);
      for (int i = 0; i < 4; i++) add(0, 4'hB, 0, 4'h4, 1, 2'd2, 0, 5);
      add(0, 4'hB, 0, 4'h0, 0, 2'd2, 1, 5);
      add(0, 4'hB, 0, 4'h4, 1, 2'd2, 0, 5);
      add(0, 4'hF, 0, 4'h0, 0, 2'd2, 0, 5);
      add(0, 4'hF, 0, 4'h0, 0, 2'd2, 1, 5);

      // start of a burst on FIFO 3
      add(0, 4'h7, 0, 4'h0, 0, 2'd2, 1, 6);
      for (int i = 0; i < 2; i++) add(0, 4'h7, 0, 4'h8, 1, 2'd3, 0, 6);

      foreach (tbl[r]) begin
         @(negedge clk);
         reset       = tbl[r].rst;
         FIFO_empty  = tbl[r].emp;
         Almost_full = tbl[r].af;
         #1;
         check(tbl[r].test, r, tbl[r].pop, tbl[r].push, tbl[r].cls, tbl[r].idle);
      end

      // reset rises in the middle of the third pop on FIFO 3
      @(negedge clk);
      #1;
      check(7, 0, 4'h8, 1, 2'd3, 0);
      #1 reset = 1'b1;
      #1;
      check(7, 1, 4'h0, 0, 2'd0, 1);
      @(negedge clk);
      FIFO_empty = 4'h0;
      #1;
      check(7, 2, 4'h0, 0, 2'd0, 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check(7, 3, 4'h0, 0, 2'd0, 1);
      @(negedge clk);
      #1;
      check(7, 4, 4'h1, 1, 2'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/arbitro_1.md
# arbitro_1

Fan-in arbiter for the switch datapath: drains four per-class input FIFOs into a single output FIFO. It uses round-robin order with a bounded burst per class. It is the counterpart of the class-demultiplexing arbiter, which pops one FIFO and pushes into four class FIFOs by `class`. This block pops one of four FIFOs, pushes into one FIFO, and drives `class` to tag the source.

## Interface
- `BURST`, default 4: maximum consecutive pops from one class before the grant is released. Legal range 1..7.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `FIFO_empty`  input  4  empty flag of class FIFO i (bit i). 1 = empty.
- `Almost_full`  input  1  almost-full flag of the output FIFO. 1 = no push allowed.
- `Pop`  output  4  one-hot pop strobe to class FIFO i.
- `Push`  output  1  push strobe to the output FIFO.
- `class`  output  2  index of the currently granted class FIFO.
- `Idle`  output  1  1 while no class is granted.

## Operation
- **State.** Registers are `state` (IDLE/SERVE), `grant[1:0]`, `last_grant[1:0]`, `count[2:0]` and `class[1:0]`.
- **Search order.** Scan from `last_grant+1` upward, modulo 4, wrapping. The first i with `FIFO_empty[i]==0` wins.
- **IDLE state.**
  - `Pop=0`, `Push=0`, `Idle=1`.
  - If any FIFO is non-empty, at the clock edge: `state<=SERVE`, `grant<=winner`, `class<=winner`, `count<=0`.
  - Otherwise stay in IDLE; all registers hold.
- **SERVE state (`Idle=0`).**
  - `fire = !FIFO_empty[grant] & !Almost_full`.
  - `Pop[grant]=fire`; all other `Pop` bits are 0. `Push=fire`.
  - `Pop` and `Push` are combinational from registered state and current flags, so a pop and its push occur in the same cycle.
- **SERVE edge actions.**
  - **fire and `count+1 < BURST`:** `count<=count+1`, stay in SERVE.
  - **fire and `count+1 == BURST`:** `state<=IDLE`, `last_grant<=grant`, `count<=0`.
  - **`FIFO_empty[grant]==1`:** `state<=IDLE`, `last_grant<=grant`, `count<=0`. This applies regardless of `Almost_full`.
  - **`Almost_full==1` and `FIFO_empty[grant]==0`:** stall. Stay in SERVE; `grant`, `class` and `count` all hold.
- **`class` output.** Changes only on entry to SERVE. It holds its value through IDLE, so it always reports the last grant.
- **Invariants.**
  - `Pop` is zero or one-hot.
  - `Push == |Pop`.
  - Never pop an empty FIFO.
  - Never push while `Almost_full` is high.

## Timing
- **Reset values (asynchronous):**
  - `state=IDLE`, `grant=0`, `last_grant=3` (so the first search starts at FIFO 0), `count=0`, `class=0`.
  - `Pop=0`, `Push=0`, `Idle=1`.
- **Reset during a burst:** `Pop` and `Push` deassert in the same cycle as `reset` rises. No partial burst state survives.
- **Grant latency:** one cycle from a non-empty flag being sampled in IDLE to the first `Pop`.
- **Release bubble:** every grant release costs exactly one IDLE cycle.
  - A burst of `BURST` pops from one class therefore occupies `BURST+1` cycles when the output never stalls.
- **Emptying the granted FIFO:** the FIFO's empty flag updates one cycle after its last pop. That cycle sees `FIFO_empty[grant]=1` and moves to IDLE with no pop.
- **Simultaneous events:**
  - **Empty and `Almost_full` in the same cycle:** empty wins and the grant is released.
  - **A class becomes non-empty during another class's burst:** it is not serviced until the current grant is released.
- **Fairness:** a class waits at most 3 bursts for service, i.e. at most 3·(`BURST`+1) cycles while the output is not stalled.

## Test plan
1. **Reset, all empty.** Release `reset` with `FIFO_empty=4'b1111`. Required for 20 cycles: `Idle=1`, `Pop=0`, `Push=0`, `class=0`.
2. **Single class, `BURST=4`.** FIFO 0 holds 6 entries; `FIFO_empty=4'b1110`. Required:
   - One grant cycle, then `Pop=4'b0001` with `Push=1` for 4 cycles, `class=0`.
   - One IDLE cycle, then FIFO 0 is re-granted and popped 2 more times.
   - Then IDLE, with 6 pushes in total.
3. **All four classes busy.** All FIFOs hold ≥8 entries and `Almost_full=0`. Required:
   - Grant order 0,1,2,3,0.
   - Each grant gives 4 consecutive pops of the matching one-hot `Pop`, with `class` equal to the FIFO index.
   - Exactly one `Idle` cycle between bursts.
4. **Output backpressure.** Raise `Almost_full` after 2 pops from FIFO 2 and hold it for 3 cycles. Required:
   - `Pop=0` and `Push=0` for those 3 cycles; `class=2` and `count` hold.
   - After `Almost_full` falls, exactly 2 more pops, then IDLE.
5. **Early empty.** FIFO 1 holds 1 entry and FIFO 2 holds 5. Required:
   - 1 pop from FIFO 1.
   - Next cycle sees it empty: IDLE.
   - Next grant is FIFO 2 (`class=2`), which gives 4 pops.
6. **Reset mid-burst.** Assert `reset` mid-cycle during a burst on FIFO 3. Required:
   - `Pop`/`Push` are 0 immediately; `class=0`; `Idle=1`.
   - After release, with all FIFOs non-empty, the first grant is FIFO 0.
